// File: rtl/arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, GNT_IF, GNT_LS)
//   arb_master_t : requester identity, used for the round-robin 'last' record
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_LS = 2'd2
  } arb_state_t;

  typedef enum logic {
    M_IF = 1'b0,
    M_LS = 1'b1
  } arb_master_t;

endpackage

// File: rtl/wb_arb_timer.sv
// Grant watchdog counter for wb_bus_arbiter (only instantiated when
// WB_ARB_TIMEOUT_EN is defined).
// Ports:
//   i_clk      : clock
//   i_rst      : synchronous active-high reset
//   i_clear    : hold count at zero (arbiter not granting)
//   i_count    : advance the count by one (grant cycle without ack)
//   o_at_limit : the current grant cycle is the TIMEOUT_CYCLES-th without ack
module wb_arb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_at_limit
);

  // The count holds the number of ack-less grant cycles already completed,
  // so it only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_count && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_at_limit = (r_count == LIMIT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master (instruction fetch, load/store) to one Wishbone-style slave
// arbiter with round-robin priority. The grant is held until the slave acks
// or the granted master drops its request.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to compile in a watchdog that
// aborts a grant after TIMEOUT_CYCLES cycles without ack (x_err pulse).
// Without it If_err/Ls_err are tied low and a grant waits indefinitely.
//
// Ports:
//   Clk, Rst                      : clock, synchronous active-high reset
//   If_addr, If_cs                : fetch request
//   If_rdata, If_ack, If_err      : fetch response
//   Ls_addr, Ls_cs, Ls_we, Ls_wdata : load/store request
//   Ls_rdata, Ls_ack, Ls_err      : load/store response
//   Wb_addr, Wb_cs, Wb_we, Wb_wdata : slave request
//   Wb_rdata, Wb_ack              : slave response
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W         = `ADDR_SIZE,
  parameter int DATA_W         = `WORD_SIZE,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] If_addr,
  input  logic              If_cs,
  output logic [DATA_W-1:0] If_rdata,
  output logic              If_ack,
  output logic              If_err,
  input  logic [ADDR_W-1:0] Ls_addr,
  input  logic              Ls_cs,
  input  logic              Ls_we,
  input  logic [DATA_W-1:0] Ls_wdata,
  output logic [DATA_W-1:0] Ls_rdata,
  output logic              Ls_ack,
  output logic              Ls_err,
  output logic [ADDR_W-1:0] Wb_addr,
  output logic              Wb_cs,
  output logic              Wb_we,
  output logic [DATA_W-1:0] Wb_wdata,
  input  logic [DATA_W-1:0] Wb_rdata,
  input  logic              Wb_ack
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  arb_master_t r_last;
  arb_master_t w_last_nxt;

  // w_at_limit is independent of Wb_ack so the slave-side outputs never
  // depend combinationally on the slave's own ack.
  logic w_at_limit;
  logic w_expire;

`ifdef WB_ARB_TIMEOUT_EN
  logic w_grant;
  logic w_cur_cs;

  assign w_grant  = (r_state != IDLE);
  assign w_cur_cs = (r_state == GNT_LS) ? Ls_cs : If_cs;

  // Cleared throughout IDLE, so every grant starts counting from zero.
  wb_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_clear    (!w_grant),
    .i_count    (w_grant && w_cur_cs && !Wb_ack),
    .o_at_limit (w_at_limit)
  );

  // An ack in the limit cycle wins: the transfer completes normally.
  assign w_expire = w_grant && w_cur_cs && w_at_limit && !Wb_ack;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_at_limit = 1'b0;
  assign w_expire   = 1'b0;
`endif

  // State and round-robin history registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_last  <= M_IF;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (Ls_cs && If_cs) begin
          w_state_nxt = (r_last == M_IF) ? GNT_LS : GNT_IF;
        end else if (Ls_cs) begin
          w_state_nxt = GNT_LS;
        end else if (If_cs) begin
          w_state_nxt = GNT_IF;
        end
      end
      GNT_IF: begin
        // Ack beats a simultaneous cs drop: that case is a completion.
        if (Wb_ack) begin
          w_state_nxt = IDLE;
          w_last_nxt  = M_IF;
        end else if (!If_cs) begin
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_state_nxt = IDLE;
          w_last_nxt  = M_IF;
        end
      end
      GNT_LS: begin
        if (Wb_ack) begin
          w_state_nxt = IDLE;
          w_last_nxt  = M_LS;
        end else if (!Ls_cs) begin
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_state_nxt = IDLE;
          w_last_nxt  = M_LS;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output muxing. Everything is held low while Rst is asserted so an ack
  // arriving in the reset cycle is not forwarded to a master.
  always_comb begin
    Wb_cs    = 1'b0;
    Wb_we    = 1'b0;
    Wb_addr  = '0;
    Wb_wdata = '0;
    If_ack   = 1'b0;
    If_err   = 1'b0;
    If_rdata = '0;
    Ls_ack   = 1'b0;
    Ls_err   = 1'b0;
    Ls_rdata = '0;
    if (!Rst) begin
      case (r_state)
        GNT_IF: begin
          Wb_cs    = If_cs && !w_at_limit;
          Wb_addr  = If_addr;
          If_ack   = Wb_ack;
          If_rdata = Wb_rdata;
          If_err   = w_expire;
        end
        GNT_LS: begin
          Wb_cs    = Ls_cs && !w_at_limit;
          Wb_addr  = Ls_addr;
          Wb_we    = Ls_we;
          Wb_wdata = Ls_wdata;
          Ls_ack   = Wb_ack;
          Ls_rdata = Wb_rdata;
          Ls_err   = w_expire;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter. Expected slave-side requests are
// queued when a master raises its request and checked when Wb_cs appears.
module tb_wb_bus_arbiter;
  import arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [AW-1:0] If_addr, Ls_addr, Wb_addr;
  logic          If_cs, Ls_cs, Ls_we, Wb_cs, Wb_we, Wb_ack;
  logic [DW-1:0] If_rdata, Ls_rdata, Ls_wdata, Wb_wdata, Wb_rdata;
  logic          If_ack, If_err, Ls_ack, Ls_err;

  always #5 Clk = ~Clk;

  wb_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .If_addr(If_addr), .If_cs(If_cs), .If_rdata(If_rdata), .If_ack(If_ack), .If_err(If_err),
    .Ls_addr(Ls_addr), .Ls_cs(Ls_cs), .Ls_we(Ls_we), .Ls_wdata(Ls_wdata),
    .Ls_rdata(Ls_rdata), .Ls_ack(Ls_ack), .Ls_err(Ls_err),
    .Wb_addr(Wb_addr), .Wb_cs(Wb_cs), .Wb_we(Wb_we), .Wb_wdata(Wb_wdata),
    .Wb_rdata(Wb_rdata), .Wb_ack(Wb_ack)
  );

  typedef struct {
    logic          is_ls;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  arb_master_t m_last = M_IF;

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_ls();
    exp_q.push_back('{1'b1, Ls_addr, Ls_we, Ls_wdata});
  endtask

  task automatic push_if();
    exp_q.push_back('{1'b0, If_addr, 1'b0, '0});
  endtask

  // Slave model: wait up to max_wait cycles for Wb_cs, check the request
  // against the queue, hold for dly cycles, then ack with rdata.
  task automatic serve(input string name, input int max_wait, input int dly,
                       input logic [DW-1:0] rdata);
    txn_t e;
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_wait && !found; i++) begin
      @(negedge Clk);
      if (Wb_cs === 1'b1) found = 1'b1;
      else if (i < max_wait - 1) next_cycle();
    end
    vectors++;
    if (!found || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s grant: Wb_cs=%b queued=%0d, required Wb_cs=1 within %0d cycles with a queued request",
               name, Wb_cs, exp_q.size(), max_wait);
      next_cycle();
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if ({Wb_addr, Wb_we, Wb_wdata} !== {e.addr, e.we, e.wdata}) begin
      miscompares++;
      $display("FAIL %s request: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
               name, Wb_addr, Wb_we, Wb_wdata, e.addr, e.we, e.wdata);
    end
    for (int d = 0; d < dly; d++) begin
      next_cycle();
      @(negedge Clk);
      vectors++;
      if (Wb_cs !== 1'b1) begin
        miscompares++;
        $display("FAIL %s hold: Wb_cs=%b, required 1", name, Wb_cs);
      end
    end
    Wb_ack = 1'b1;
    Wb_rdata = rdata;
    #1;
    vectors++;
    if ({If_ack, Ls_ack, If_err, Ls_err} !== (e.is_ls ? 4'b0100 : 4'b1000)) begin
      miscompares++;
      $display("FAIL %s ack: {If_ack,Ls_ack,If_err,Ls_err}=%b, required %b",
               name, {If_ack, Ls_ack, If_err, Ls_err}, (e.is_ls ? 4'b0100 : 4'b1000));
    end
    vectors++;
    if ({If_rdata, Ls_rdata} !== (e.is_ls ? {DW'(0), rdata} : {rdata, DW'(0)})) begin
      miscompares++;
      $display("FAIL %s rdata: If_rdata=%h Ls_rdata=%h, required If_rdata=%h Ls_rdata=%h",
               name, If_rdata, Ls_rdata, (e.is_ls ? DW'(0) : rdata), (e.is_ls ? rdata : DW'(0)));
    end
    next_cycle();
    Wb_ack = 1'b0;
    Wb_rdata = '0;
    m_last = e.is_ls ? M_LS : M_IF;
  endtask

  task automatic test_reset();
    Rst = 1'b1; If_cs = 1'b1; If_addr = 12'h123;
    Ls_cs = 1'b0; Ls_addr = '0; Ls_we = 1'b0; Ls_wdata = '0;
    Wb_ack = 1'b1; Wb_rdata = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      vectors++;
      if ({Wb_cs, Wb_we, Wb_addr, Wb_wdata, If_ack, Ls_ack, If_err, Ls_err, If_rdata, Ls_rdata} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: Wb_cs=%b Wb_we=%b Wb_addr=%h Wb_wdata=%h acks=%b%b errs=%b%b rdata=%h/%h, required all 0",
                 i, Wb_cs, Wb_we, Wb_addr, Wb_wdata, If_ack, Ls_ack, If_err, Ls_err, If_rdata, Ls_rdata);
      end
      next_cycle();
    end
    Rst = 1'b0; Wb_ack = 1'b0; Wb_rdata = '0;
    push_if();
    @(negedge Clk);
    vectors++;
    if (Wb_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_c1: Wb_cs=%b, required 0", Wb_cs);
    end
    next_cycle();
    serve("reset_first_grant", 1, 0, 16'h00AA);
    If_cs = 1'b0;
  endtask

  task automatic test_round_robin();
    If_cs = 1'b1; If_addr = 12'h200;
    Ls_cs = 1'b1; Ls_addr = 12'h300; Ls_we = 1'b1; Ls_wdata = 16'h5A00;
    if (m_last == M_IF) begin push_ls(); push_if(); end
    else begin push_if(); push_ls(); end
    for (int g = 0; g < 6; g++) begin
      serve($sformatf("rr_grant%0d", g), 2, 1, DW'(16'h0040 + g));
      if (m_last == M_LS) begin
        Ls_addr = Ls_addr + 12'h001; Ls_wdata = Ls_wdata + 16'h0011; Ls_we = ~Ls_we;
        if (g < 4) push_ls();
      end else begin
        If_addr = If_addr + 12'h004;
        if (g < 4) push_if();
      end
    end
    If_cs = 1'b0; Ls_cs = 1'b0;
    next_cycle();
  endtask

  task automatic test_load_back_to_back();
    Ls_cs = 1'b1; Ls_we = 1'b0; Ls_addr = 12'hFFF; Ls_wdata = 16'h1111;
    push_ls();
    serve("ls_load_fff", 2, 0, 16'd101);
    Ls_addr = 12'hFFE;
    push_ls();
    @(negedge Clk);
    vectors++;
    if ({Wb_cs, Ls_ack, If_ack, If_rdata, Ls_rdata} !== '0) begin
      miscompares++;
      $display("FAIL ls_idle_gap: Wb_cs=%b Ls_ack=%b If_ack=%b If_rdata=%h Ls_rdata=%h, required all 0",
               Wb_cs, Ls_ack, If_ack, If_rdata, Ls_rdata);
    end
    next_cycle();
    serve("ls_back_to_back", 1, 0, 16'd7);
    Ls_cs = 1'b0;
  endtask

  task automatic test_idle_ack();
    If_cs = 1'b0; Ls_cs = 1'b0;
    Wb_ack = 1'b1; Wb_rdata = 16'hDEAD;
    @(negedge Clk);
    vectors++;
    if ({Wb_cs, If_ack, Ls_ack, If_rdata, Ls_rdata} !== '0) begin
      miscompares++;
      $display("FAIL idle_ack: Wb_cs=%b If_ack=%b Ls_ack=%b If_rdata=%h Ls_rdata=%h, required all 0",
               Wb_cs, If_ack, Ls_ack, If_rdata, Ls_rdata);
    end
    next_cycle();
    Wb_ack = 1'b0; Wb_rdata = '0;
    Ls_cs = 1'b1; Ls_addr = 12'h0A5; Ls_we = 1'b1; Ls_wdata = 16'hC0DE;
    push_ls();
    @(negedge Clk);
    vectors++;
    if (Wb_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack_arbitration: Wb_cs=%b, required 0", Wb_cs);
    end
    next_cycle();
    serve("after_idle_ack", 1, 0, 16'h0000);
    Ls_cs = 1'b0;
  endtask

  task automatic test_abandon();
    If_cs = 1'b1; If_addr = 12'h0F0;
    next_cycle();
    @(negedge Clk);
    vectors++;
    if ({Wb_cs, Wb_addr, Wb_we} !== {1'b1, 12'h0F0, 1'b0}) begin
      miscompares++;
      $display("FAIL abandon_grant: Wb_cs=%b Wb_addr=%h Wb_we=%b, required 1/0f0/0", Wb_cs, Wb_addr, Wb_we);
    end
    next_cycle();
    If_cs = 1'b0;
    Ls_cs = 1'b1; Ls_addr = 12'h777; Ls_we = 1'b0; Ls_wdata = 16'h0000;
    push_ls();
    @(negedge Clk);
    vectors++;
    if ({Wb_cs, If_ack, Ls_ack} !== 3'b000) begin
      miscompares++;
      $display("FAIL abandon_drop: Wb_cs=%b If_ack=%b Ls_ack=%b, required 000", Wb_cs, If_ack, Ls_ack);
    end
    next_cycle();
    @(negedge Clk);
    vectors++;
    if ({Wb_cs, If_ack, Ls_ack} !== 3'b000) begin
      miscompares++;
      $display("FAIL abandon_idle: Wb_cs=%b If_ack=%b Ls_ack=%b, required 000", Wb_cs, If_ack, Ls_ack);
    end
    next_cycle();
    serve("abandon_then_ls", 1, 0, 16'h0033);
    Ls_cs = 1'b0;
  endtask

  task automatic test_reset_midgrant();
    If_cs = 1'b1; If_addr = 12'h456;
    next_cycle();
    @(negedge Clk);
    vectors++;
    if (Wb_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_grant: Wb_cs=%b, required 1", Wb_cs);
    end
    Rst = 1'b1; Wb_ack = 1'b1; Wb_rdata = 16'h9999;
    #1;
    vectors++;
    if ({Wb_cs, If_ack, If_rdata} !== '0) begin
      miscompares++;
      $display("FAIL midreset_drop: Wb_cs=%b If_ack=%b If_rdata=%h, required all 0", Wb_cs, If_ack, If_rdata);
    end
    next_cycle();
    Rst = 1'b0; Wb_ack = 1'b0; Wb_rdata = '0;
    m_last = M_IF;
    push_if();
    @(negedge Clk);
    vectors++;
    if (Wb_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: Wb_cs=%b, required 0", Wb_cs);
    end
    next_cycle();
    serve("post_midreset", 1, 0, 16'h0456);
    If_cs = 1'b0;
  endtask

  task automatic test_timeout();
    Ls_cs = 1'b1; Ls_addr = 12'h3C3; Ls_we = 1'b1; Ls_wdata = 16'hABCD;
    next_cycle();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= TO; c++) begin
      logic [3:0] req;
      req = (c == TO) ? 4'b0100 : 4'b1000;
      @(negedge Clk);
      vectors++;
      if ({Wb_cs, Ls_err, If_err, Ls_ack} !== req) begin
        miscompares++;
        $display("FAIL timeout_cycle%0d: {Wb_cs,Ls_err,If_err,Ls_ack}=%b, required %b",
                 c, {Wb_cs, Ls_err, If_err, Ls_ack}, req);
      end
      next_cycle();
    end
    Wb_ack = 1'b1;
    @(negedge Clk);
    vectors++;
    if ({Wb_cs, Ls_err, Ls_ack, If_ack} !== 4'b0000) begin
      miscompares++;
      $display("FAIL timeout_late_ack: {Wb_cs,Ls_err,Ls_ack,If_ack}=%b, required 0000",
               {Wb_cs, Ls_err, Ls_ack, If_ack});
    end
    next_cycle();
    Wb_ack = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({Wb_cs, Ls_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout_regrant: Wb_cs=%b Ls_err=%b, required 1/0", Wb_cs, Ls_err);
    end
`else
    for (int c = 1; c <= 25; c++) begin
      @(negedge Clk);
      vectors++;
      if ({Wb_cs, Ls_err, If_err} !== 3'b100) begin
        miscompares++;
        $display("FAIL no_timeout_cycle%0d: {Wb_cs,Ls_err,If_err}=%b, required 100",
                 c, {Wb_cs, Ls_err, If_err});
      end
      next_cycle();
    end
    @(negedge Clk);
`endif
    Ls_cs = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_load_back_to_back();
    test_idle_ack();
    test_abandon();
    test_reset_midgrant();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t, required completion", $time);
    $fatal(1, "time limit");
  end

endmodule
